// File: rtl/ascon_sequencer_if.sv
// Handshake and control bundle between the ASCON sequencer and its environment.
// The slave modport is the sequencer; the master side drives the data stream.
interface ascon_sequencer_if;
    logic       start_i;
    logic       ad_present_i;
    logic       data_valid_i;
    logic       data_last_i;
    logic       data_ready_o;
    logic       data_sel_o;
    logic [3:0] counter_o;
    logic       en_xor_data_o;
    logic       en_xor_key_o;
    logic       en_xor_key_end_o;
    logic       en_xor_lsb_o;
    logic       en_reg_state_o;
    logic       en_cipher_o;
    logic       en_tag_o;
    logic       cipher_valid_o;
    logic       tag_valid_o;
    logic       busy_o;
    logic       done_o;

    modport master (
        output start_i, ad_present_i, data_valid_i, data_last_i,
        input  data_ready_o, data_sel_o, counter_o,
        input  en_xor_data_o, en_xor_key_o, en_xor_key_end_o,
        input  en_xor_lsb_o, en_reg_state_o, en_cipher_o, en_tag_o,
        input  cipher_valid_o, tag_valid_o, busy_o, done_o
    );

    modport slave (
        input  start_i, ad_present_i, data_valid_i, data_last_i,
        output data_ready_o, data_sel_o, counter_o,
        output en_xor_data_o, en_xor_key_o, en_xor_key_end_o,
        output en_xor_lsb_o, en_reg_state_o, en_cipher_o, en_tag_o,
        output cipher_valid_o, tag_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/ascon_sequencer.sv
// Control FSM for a one-round-per-cycle ASCON-128 permutation datapath.
// Sequences init, associated data, plaintext, finalisation and tag.
module ascon_sequencer #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input logic               clock_i,
    input logic               reset_i,
    ascon_sequencer_if.slave  bus
);

    localparam logic [3:0] IDX_A = 4'(12 - ROUNDS_A);
    localparam logic [3:0] IDX_B = 4'(12 - ROUNDS_B);
    localparam logic [3:0] IDX_L = 4'd11;

    typedef enum logic [2:0] {
        IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       adp_q, adp_d;
    logic       adl_q, adl_d;
    logic       cv_q, tv_q, done_q;

    logic       ready, sel, xd, xk, xke, xl, rs, ci, tg, busy;
    logic [3:0] cnt;
    logic       last_rnd;
    logic       start_acc;

    assign last_rnd  = (cnt_q == IDX_L);
    assign start_acc = (state_q == IDLE) && bus.start_i;

    // Next-state, round counter and Mealy enable decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adp_d   = adp_q;
        adl_d   = adl_q;
        ready   = 1'b0;
        sel     = 1'b0;
        cnt     = 4'd0;
        xd      = 1'b0;
        xk      = 1'b0;
        xke     = 1'b0;
        xl      = 1'b0;
        rs      = 1'b0;
        ci      = 1'b0;
        tg      = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = INIT;
                    cnt_d   = IDX_A;
                    adp_d   = bus.ad_present_i;
                end
            end
            INIT: begin
                busy  = 1'b1;
                rs    = 1'b1;
                sel   = (cnt_q != IDX_A);
                cnt   = cnt_q;
                cnt_d = cnt_q + 4'd1;
                if (last_rnd) begin
                    xke     = 1'b1;
                    xl      = ~adp_q;
                    cnt_d   = 4'd0;
                    state_d = adp_q ? WAIT_AD : WAIT_PT;
                end
            end
            WAIT_AD: begin
                busy  = 1'b1;
                ready = 1'b1;
                sel   = 1'b1;
                if (bus.data_valid_i) begin
                    xd      = 1'b1;
                    rs      = 1'b1;
                    cnt     = IDX_B;
                    cnt_d   = IDX_B + 4'd1;
                    adl_d   = bus.data_last_i;
                    state_d = AD;
                end
            end
            AD, PT: begin
                busy  = 1'b1;
                sel   = 1'b1;
                rs    = 1'b1;
                cnt   = cnt_q;
                cnt_d = cnt_q + 4'd1;
                if (last_rnd) begin
                    xl      = (state_q == AD) && adl_q;
                    cnt_d   = 4'd0;
                    state_d = ((state_q == AD) && !adl_q) ? WAIT_AD : WAIT_PT;
                end
            end
            WAIT_PT: begin
                busy  = 1'b1;
                ready = 1'b1;
                sel   = 1'b1;
                if (bus.data_valid_i) begin
                    xd = 1'b1;
                    ci = 1'b1;
                    rs = 1'b1;
                    if (bus.data_last_i) begin
                        xk      = 1'b1;
                        cnt     = IDX_A;
                        cnt_d   = IDX_A + 4'd1;
                        state_d = FINAL;
                    end else begin
                        cnt     = IDX_B;
                        cnt_d   = IDX_B + 4'd1;
                        state_d = PT;
                    end
                end
            end
            FINAL: begin
                busy  = 1'b1;
                sel   = 1'b1;
                rs    = 1'b1;
                cnt   = cnt_q;
                cnt_d = cnt_q + 4'd1;
                if (last_rnd) begin
                    xke     = 1'b1;
                    tg      = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter and latched phase flags; reset aborts any operation.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            adp_q   <= 1'b0;
            adl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adp_q   <= adp_d;
            adl_q   <= adl_d;
        end
    end

    // Status flags that report what the datapath registers now hold.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cv_q   <= 1'b0;
            tv_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cv_q   <= ci;
            done_q <= tg;
            if (tg)
                tv_q <= 1'b1;
            else if (start_acc)
                tv_q <= 1'b0;
        end
    end

    // Outputs are forced low while reset is held so no enable escapes.
    always_comb begin
        bus.data_ready_o     = ready & ~reset_i;
        bus.data_sel_o       = sel & ~reset_i;
        bus.counter_o        = reset_i ? 4'd0 : cnt;
        bus.en_xor_data_o    = xd & ~reset_i;
        bus.en_xor_key_o     = xk & ~reset_i;
        bus.en_xor_key_end_o = xke & ~reset_i;
        bus.en_xor_lsb_o     = xl & ~reset_i;
        bus.en_reg_state_o   = rs & ~reset_i;
        bus.en_cipher_o      = ci & ~reset_i;
        bus.en_tag_o         = tg & ~reset_i;
        bus.busy_o           = busy & ~reset_i;
        bus.cipher_valid_o   = cv_q;
        bus.tag_valid_o      = tv_q;
        bus.done_o           = done_q;
    end

endmodule
